// File: rtl/cs_backprojection_decoder_if.sv
// Bus bundle for the back-projection decoder: Phi load port, measurement
// stream in, estimate stream out, and status flags.
interface cs_backprojection_decoder_if #(
    parameter int IN_W  = 4,
    parameter int ACC_W = 10
);
    logic             phi_we;
    logic [5:0]       phi_row;
    logic [6:0]       phi_col;
    logic [1:0]       phi_code;
    logic             phi_err;
    logic             meas_valid;
    logic [IN_W-1:0]  meas_data;
    logic             meas_ready;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [6:0]       out_col;
    logic             out_last;
    logic             busy;

    modport master (
        output phi_we, phi_row, phi_col, phi_code, meas_valid, meas_data, out_ready,
        input  phi_err, meas_ready, out_valid, out_data, out_col, out_last, busy
    );

    modport slave (
        input  phi_we, phi_row, phi_col, phi_code, meas_valid, meas_data, out_ready,
        output phi_err, meas_ready, out_valid, out_data, out_col, out_last, busy
    );
endinterface

// File: rtl/cs_backprojection_decoder.sv
// Compressed-sensing receive end: buffers a 48-sample frame, then streams the
// ternary back-projection x_hat[j] = sum_i Phi[i][j]*y[i] one column at a time.
module cs_backprojection_decoder #(
    parameter int IN_W   = 4,
    parameter int ACC_W  = 10,
    parameter int THRESH = 0
) (
    input  logic                       sys_clk_i,
    input  logic                       sys_reset_i,
    cs_backprojection_decoder_if.slave bus
);
    localparam int ROWS = 48;
    localparam int COLS = 96;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_ACCUM   = 2'd2;
    localparam logic [1:0] S_EMIT    = 2'd3;

    localparam logic [ACC_W:0] THRESH_MAG = THRESH[ACC_W:0];

    // Matrix and frame storage are deliberately left out of reset.
    logic [1:0]              phi_q  [ROWS][COLS];
    logic signed [ACC_W-1:0] ybuf_q [ROWS];

    logic [1:0]              state_q, state_d;
    logic [5:0]              k_q, k_d;
    logic [5:0]              row_q, row_d;
    logic [6:0]              col_q, col_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    out_valid_q, out_valid_d;
    logic [ACC_W-1:0]        out_data_q, out_data_d;
    logic [6:0]              out_col_q, out_col_d;
    logic                    out_last_q, out_last_d;
    logic                    meas_ready_q;
    logic                    phi_err_q;

    logic                    meas_hs;
    logic                    out_hs;
    logic                    phi_ok;
    logic [1:0]              phi_rd;
    logic signed [ACC_W-1:0] y_rd;
    logic signed [ACC_W-1:0] y_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic [ACC_W:0]          acc_ext;
    logic [ACC_W:0]          acc_mag;
    logic [ACC_W-1:0]        thr_val;

    assign meas_hs = bus.meas_valid & meas_ready_q;
    assign out_hs  = out_valid_q & bus.out_ready;
    assign phi_ok  = bus.phi_we && (state_q == S_IDLE || state_q == S_CAPTURE)
                     && (bus.phi_row < 6'd48) && (bus.phi_col < 7'd96);
    assign y_ext   = {{(ACC_W-IN_W){bus.meas_data[IN_W-1]}}, bus.meas_data};

    assign phi_rd = phi_q[row_q][col_q];
    assign y_rd   = ybuf_q[row_q];

    // Reserved code 2'b10 contributes nothing, same as 2'b00.
    always_comb begin
        acc_sum = acc_q;
        case (phi_rd)
            2'b01:   acc_sum = acc_q + y_rd;
            2'b11:   acc_sum = acc_q - y_rd;
            default: acc_sum = acc_q;
        endcase
    end

    // One extra bit keeps |-512| representable for the threshold compare.
    assign acc_ext = {acc_sum[ACC_W-1], acc_sum};
    assign acc_mag = acc_sum[ACC_W-1] ? (~acc_ext + (ACC_W+1)'(1)) : acc_ext;
    assign thr_val = (acc_mag >= THRESH_MAG) ? acc_sum : '0;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        row_d       = row_q;
        col_d       = col_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        case (state_q)
            S_IDLE, S_CAPTURE: begin
                if (meas_hs) begin
                    if (k_q == 6'd47) begin
                        k_d     = '0;
                        row_d   = '0;
                        col_d   = '0;
                        acc_d   = '0;
                        state_d = S_ACCUM;
                    end else begin
                        k_d     = k_q + 6'd1;
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_ACCUM: begin
                acc_d = acc_sum;
                if (row_q == 6'd47) begin
                    out_valid_d = 1'b1;
                    out_data_d  = thr_val;
                    out_col_d   = col_q;
                    out_last_d  = (col_q == 7'd95);
                    state_d     = S_EMIT;
                end else begin
                    row_d = row_q + 6'd1;
                end
            end
            S_EMIT: begin
                if (out_hs) begin
                    out_valid_d = 1'b0;
                    if (col_q == 7'd95) begin
                        state_d = S_IDLE;
                    end else begin
                        col_d   = col_q + 7'd1;
                        row_d   = '0;
                        acc_d   = '0;
                        state_d = S_ACCUM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_reset_i) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            row_q        <= '0;
            col_q        <= '0;
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_col_q    <= '0;
            out_last_q   <= 1'b0;
            meas_ready_q <= 1'b0;
            phi_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            row_q        <= row_d;
            col_q        <= col_d;
            acc_q        <= acc_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_col_q    <= out_col_d;
            out_last_q   <= out_last_d;
            meas_ready_q <= (state_d == S_IDLE) || (state_d == S_CAPTURE);
            phi_err_q    <= bus.phi_we & ~phi_ok;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_reset_i) begin
            if (phi_ok)  phi_q[bus.phi_row][bus.phi_col] <= bus.phi_code;
            if (meas_hs) ybuf_q[k_q] <= y_ext;
        end
    end

    assign bus.meas_ready = meas_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_col    = out_col_q;
    assign bus.out_last   = out_last_q;
    assign bus.phi_err    = phi_err_q;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_cs_backprojection_decoder.sv
// Bench for the back-projection decoder: a pass-through and a THRESH=4 instance
// run in lockstep from the same stimulus, checked against an adjoint model.
module tb_cs_backprojection_decoder;
    localparam int IN_W  = 4;
    localparam int ACC_W = 10;
    localparam int ROWS  = 48;
    localparam int COLS  = 96;

    logic sys_clk = 1'b0;
    logic sys_reset = 1'b1;
    always #5 sys_clk = ~sys_clk;

    logic            phi_we = 1'b0;
    logic [5:0]      phi_row = '0;
    logic [6:0]      phi_col = '0;
    logic [1:0]      phi_code = '0;
    logic            meas_valid = 1'b0;
    logic [IN_W-1:0] meas_data = '0;
    logic            out_ready = 1'b0;

    cs_backprojection_decoder_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus0 ();
    cs_backprojection_decoder_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus4 ();

    assign bus0.phi_we = phi_we;         assign bus4.phi_we = phi_we;
    assign bus0.phi_row = phi_row;       assign bus4.phi_row = phi_row;
    assign bus0.phi_col = phi_col;       assign bus4.phi_col = phi_col;
    assign bus0.phi_code = phi_code;     assign bus4.phi_code = phi_code;
    assign bus0.meas_valid = meas_valid; assign bus4.meas_valid = meas_valid;
    assign bus0.meas_data = meas_data;   assign bus4.meas_data = meas_data;
    assign bus0.out_ready = out_ready;   assign bus4.out_ready = out_ready;

    cs_backprojection_decoder #(.IN_W(IN_W), .ACC_W(ACC_W), .THRESH(0)) dut0 (
        .sys_clk_i(sys_clk), .sys_reset_i(sys_reset), .bus(bus0));
    cs_backprojection_decoder #(.IN_W(IN_W), .ACC_W(ACC_W), .THRESH(4)) dut4 (
        .sys_clk_i(sys_clk), .sys_reset_i(sys_reset), .bus(bus4));

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] m_code [ROWS][COLS];
    logic [1:0] want   [ROWS][COLS];
    logic [3:0] y_raw  [ROWS];
    int         y_m    [ROWS];
    int         got0   [COLS];
    int         got4   [COLS];

    typedef struct {
        int phi_pat; int y_pat; int mode; int stall_col; bit cap_wr;
        int col_a; int exp_a; int thr_a;
        int col_b; int exp_b; int thr_b;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int code_val(input logic [1:0] c);
        return (c == 2'b01) ? 1 : (c == 2'b11) ? -1 : 0;
    endfunction

    function automatic int thr(input int x, input int t);
        int m;
        m = (x < 0) ? -x : x;
        return (m >= t) ? x : 0;
    endfunction

    function automatic int exp_col(input int j);
        int s = 0;
        for (int i = 0; i < ROWS; i++) s += code_val(m_code[i][j]) * y_m[i];
        return s;
    endfunction

    task automatic set_want(input int pat);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                want[r][c] = (pat == 3) ? 2'($urandom_range(0, 3)) : 2'b00;
        if (pat == 0 || pat == 1)
            for (int i = 0; i < ROWS; i++) want[i][i] = 2'b01;
        if (pat == 1)
            for (int i = 0; i < ROWS; i++) begin want[i][5] = 2'b11; want[i][6] = 2'b01; end
        if (pat == 2) begin
            for (int i = 0; i < 3; i++) want[i][0] = 2'b01;
            for (int i = 0; i < 4; i++) want[i][1] = 2'b11;
        end
    endtask

    task automatic set_y(input int pat);
        for (int i = 0; i < ROWS; i++) begin
            case (pat)
                0:       y_raw[i] = 4'(i % 8);
                1:       y_raw[i] = 4'h7;
                2:       y_raw[i] = 4'h8;
                3:       y_raw[i] = 4'h1;
                default: y_raw[i] = 4'($urandom_range(0, 15));
            endcase
            y_m[i] = int'($signed(y_raw[i]));
        end
    endtask

    task automatic phi_write(input int r, input int c, input logic [1:0] code);
        phi_we = 1'b1; phi_row = 6'(r); phi_col = 7'(c); phi_code = code;
        @(negedge sys_clk);
        phi_we = 1'b0;
    endtask

    task automatic load_phi(input bit full);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (full || want[r][c] !== m_code[r][c]) begin
                    phi_write(r, c, want[r][c]);
                    m_code[r][c] = want[r][c];
                end
        check("phi_err_on_good_write", int'(bus0.phi_err), 0);
    endtask

    // Optionally lands a Phi write on the same edge as measurement 20.
    task automatic send_frame(input bit gaps, input bit cap_wr);
        int k = 0;
        int guard = 0;
        logic [1:0] code;
        while (k < ROWS && guard < 1000) begin
            guard++;
            phi_we = 1'b0;
            if (bus0.meas_ready && !(gaps && $urandom_range(0, 3) == 0)) begin
                meas_valid = 1'b1;
                meas_data  = y_raw[k];
                if (cap_wr && k == 20) begin
                    code = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
                    phi_we = 1'b1; phi_row = 6'd47; phi_col = 7'd95; phi_code = code;
                    m_code[47][95] = code;
                end
                @(negedge sys_clk);
                k++;
            end else begin
                meas_valid = 1'b0;
                @(negedge sys_clk);
            end
        end
        phi_we = 1'b0;
        meas_valid = 1'b0;
        if (k < ROWS) check("meas_accept_timeout", k, ROWS);
    endtask

    // Latency is counted in falling edges from the edge that set up the
    // accepting handshake; 48 cycles of accumulation land on the 49th.
    task automatic collect(input int mode, input int stall_col, input bit inject, input int ncols);
        int wait_n, stall, ex;
        logic [ACC_W-1:0] hd;
        logic [6:0] hc;
        logic hl;
        wait_n = 1;
        for (int col = 0; col < ncols; col++) begin
            do begin
                @(negedge sys_clk);
                out_ready = 1'b0;
                phi_we = 1'b0;
                wait_n++;
                if (inject && col == 2) begin
                    if (wait_n == 10) begin
                        phi_we = 1'b1; phi_row = 6'd0; phi_col = 7'd2;
                        phi_code = (m_code[0][2] == 2'b01) ? 2'b11 : 2'b01;
                    end
                    if (wait_n == 11) check("phi_err_pulse_accum", int'(bus0.phi_err), 1);
                    if (wait_n == 12) check("phi_err_clear_accum", int'(bus0.phi_err), 0);
                end
            end while (!bus0.out_valid && wait_n < 200);
            if (!bus0.out_valid) begin
                check($sformatf("out_valid_timeout_c%0d", col), 0, 1);
                return;
            end
            ex = exp_col(col);
            got0[col] = int'($signed(bus0.out_data));
            got4[col] = int'($signed(bus4.out_data));
            check($sformatf("latency_c%0d", col), wait_n, 49);
            check($sformatf("data_c%0d", col), got0[col], ex);
            check($sformatf("data_thr4_c%0d", col), got4[col], thr(ex, 4));
            check($sformatf("out_col_c%0d", col), int'(bus0.out_col), col);
            check($sformatf("out_last_c%0d", col), int'(bus0.out_last), (col == 95) ? 1 : 0);
            hd = bus0.out_data; hc = bus0.out_col; hl = bus0.out_last;
            stall = (col == stall_col) ? 20 : (mode == 1) ? int'($urandom_range(0, 3)) : 0;
            for (int s = 0; s < stall; s++) begin
                @(negedge sys_clk);
                check($sformatf("stall_hold_c%0d", col),
                      (bus0.out_valid && bus0.out_data == hd && bus0.out_col == hc
                       && bus0.out_last == hl) ? 1 : 0, 1);
            end
            out_ready = 1'b1;
            wait_n = 0;
        end
        if (ncols == COLS) begin
            @(negedge sys_clk);
            out_ready = 1'b0;
            check("frame_end_out_valid", int'(bus0.out_valid), 0);
            check("frame_end_busy", int'(bus0.busy), 0);
            check("frame_end_meas_ready", int'(bus0.meas_ready), 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, int'(bus0.out_valid), 0);
        check({tag, "_out_data"}, int'(bus0.out_data), 0);
        check({tag, "_out_col"}, int'(bus0.out_col), 0);
        check({tag, "_out_last"}, int'(bus0.out_last), 0);
        check({tag, "_meas_ready"}, int'(bus0.meas_ready), 0);
        check({tag, "_phi_err"}, int'(bus0.phi_err), 0);
        check({tag, "_busy"}, int'(bus0.busy), 0);
    endtask

    task automatic bad_idle_write(input int r, input int c);
        phi_write(r, c, 2'b01);
        check($sformatf("phi_err_pulse_r%0d_c%0d", r, c), int'(bus0.phi_err), 1);
        @(negedge sys_clk);
        check($sformatf("phi_err_clear_r%0d_c%0d", r, c), int'(bus0.phi_err), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        vecs[0] = '{0, 0, 0, -1, 1'b0,  7,    7,    7, 50,   0,   0};
        vecs[1] = '{1, 1, 2, 10, 1'b0,  5, -336, -336,  6, 336, 336};
        vecs[2] = '{1, 2, 1, -1, 1'b0,  6, -384, -384,  5, 384, 384};
        vecs[3] = '{2, 3, 1, -1, 1'b1,  0,    3,    0,  1,  -4,  -4};
        vecs[4] = '{3, 4, 1, -1, 1'b1, -1,    0,    0, -1,   0,   0};

        repeat (3) @(negedge sys_clk);
        check_all_zero("reset");
        sys_reset = 1'b0;
        @(negedge sys_clk);
        check("post_reset_meas_ready", int'(bus0.meas_ready), 1);
        check("post_reset_busy", int'(bus0.busy), 0);

        for (int v = 0; v < 5; v++) begin
            set_want(vecs[v].phi_pat);
            load_phi(v == 0);
            set_y(vecs[v].y_pat);
            send_frame(vecs[v].mode == 1, vecs[v].cap_wr);
            collect(vecs[v].mode, vecs[v].stall_col, 1'b0, COLS);
            if (vecs[v].col_a >= 0) begin
                check($sformatf("vec%0d_spot_a", v), got0[vecs[v].col_a], vecs[v].exp_a);
                check($sformatf("vec%0d_spot_a_thr", v), got4[vecs[v].col_a], vecs[v].thr_a);
                check($sformatf("vec%0d_spot_b", v), got0[vecs[v].col_b], vecs[v].exp_b);
                check($sformatf("vec%0d_spot_b_thr", v), got4[vecs[v].col_b], vecs[v].thr_b);
            end
        end

        // Dropped write while accumulating, then a frame that would expose it.
        set_y(4);
        send_frame(1'b0, 1'b0);
        collect(0, -1, 1'b1, COLS);
        set_y(4);
        y_raw[0] = 4'd5; y_m[0] = 5;
        send_frame(1'b0, 1'b0);
        collect(0, -1, 1'b0, COLS);

        // Out-of-range addresses in IDLE.
        bad_idle_write(48, 0);
        bad_idle_write(0, 96);
        set_y(4);
        send_frame(1'b0, 1'b0);
        collect(0, -1, 1'b0, COLS);

        // Reset part-way through a frame.
        set_y(4);
        send_frame(1'b0, 1'b0);
        collect(0, -1, 1'b0, 30);
        @(negedge sys_clk);
        out_ready = 1'b0;
        repeat (20) @(negedge sys_clk);
        sys_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            check_all_zero($sformatf("midreset%0d", i));
        end
        sys_reset = 1'b0;
        @(negedge sys_clk);
        check("midreset_release_meas_ready", int'(bus0.meas_ready), 1);
        seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge sys_clk);
            if (bus0.out_valid) seen++;
        end
        out_ready = 1'b0;
        check("midreset_no_out_valid", seen, 0);
        set_y(4);
        send_frame(1'b1, 1'b0);
        collect(1, -1, 1'b0, COLS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
